// File: rtl/symbol_scrambler.sv
// symbol_scrambler: rotates each I/Q symbol by R_n*90 degrees using the 2-bit
// randomizer output. It also drives the randomizer's enable and reset so that
// symbol 0 of every frame is scrambled with the seed state. The module has
// valid/ready handshakes on both sides and one output register stage.
module symbol_scrambler #(
    parameter int W         = 8,
    parameter int FRAME_LEN = 64
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_sof,
    input  logic [W-1:0] i_i,
    input  logic [W-1:0] i_q,
    input  logic [1:0]   i_r,
    output logic         o_rand_en,
    output logic         o_rand_reset,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_i,
    output logic [W-1:0] o_q,
    output logic         o_sof,
    output logic         o_eof,
    output logic         o_sat,
    output logic         o_sync_err
);

    localparam int CW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q;
    logic [W-1:0]  i_out_q, q_out_q;
    logic          sof_q, eof_q, sat_q, sync_err_q;

    logic          out_free;
    logic          fwd, fwd_sof, fwd_eof, err_d;
    logic          ready, rand_en, rand_reset;
    logic [W:0]    neg_i, neg_q;
    logic [W-1:0]  rot_i, rot_q;
    logic          rot_sat;

    // Saturating negation; returns {saturated, value}. Only the most negative
    // value cannot be negated exactly and is clamped to the most positive.
    function automatic logic [W:0] sat_neg(input logic signed [W-1:0] x);
        if (x == S_MIN) begin
            return {1'b1, S_MAX};
        end
        return {1'b0, -x};
    endfunction

    assign neg_i    = sat_neg(i_i);
    assign neg_q    = sat_neg(i_q);
    assign out_free = !valid_q || i_ready;

    // Complex rotation by i_r * 90 degrees, sampled in the accept cycle.
    always_comb begin
        rot_i   = i_i;
        rot_q   = i_q;
        rot_sat = 1'b0;
        case (i_r)
            2'd1: begin
                rot_i   = neg_q[W-1:0];
                rot_q   = i_i;
                rot_sat = neg_q[W];
            end
            2'd2: begin
                rot_i   = neg_i[W-1:0];
                rot_q   = neg_q[W-1:0];
                rot_sat = neg_i[W] | neg_q[W];
            end
            2'd3: begin
                rot_i   = i_q;
                rot_q   = neg_i[W-1:0];
                rot_sat = neg_i[W];
            end
            default: begin
                rot_i   = i_i;
                rot_q   = i_q;
                rot_sat = 1'b0;
            end
        endcase
    end

    // Frame FSM: next state, symbol count, handshake and randomizer control.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ready      = 1'b0;
        rand_en    = 1'b0;
        rand_reset = 1'b0;
        fwd        = 1'b0;
        fwd_sof    = 1'b0;
        fwd_eof    = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                ready      = out_free;
                rand_reset = 1'b1;
                if (i_valid && out_free) begin
                    if (i_sof) begin
                        fwd        = 1'b1;
                        fwd_sof    = 1'b1;
                        rand_en    = 1'b1;
                        rand_reset = 1'b0;
                        count_d    = CW'(1);
                        state_d    = ACTIVE;
                    end else begin
                        // Symbol outside any frame: dropped, flagged.
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                ready = out_free && !(i_valid && i_sof);
                if (i_valid && i_sof) begin
                    // Early frame start: abandon this frame and re-seed; the
                    // held symbol is taken next cycle from IDLE.
                    rand_reset = 1'b1;
                    err_d      = 1'b1;
                    count_d    = '0;
                    state_d    = IDLE;
                end else if (i_valid && out_free) begin
                    fwd = 1'b1;
                    if (count_q == LAST) begin
                        fwd_eof    = 1'b1;
                        rand_reset = 1'b1;
                        count_d    = '0;
                        state_d    = IDLE;
                    end else begin
                        rand_en = 1'b1;
                        count_d = count_q + CW'(1);
                    end
                end
            end
        endcase
    end

    // State and count registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Output register: loads on a forwarded accept, drains on downstream ready.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q    <= 1'b0;
            i_out_q    <= '0;
            q_out_q    <= '0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            sat_q      <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= err_d;
            if (fwd) begin
                valid_q <= 1'b1;
                i_out_q <= rot_i;
                q_out_q <= rot_q;
                sof_q   <= fwd_sof;
                eof_q   <= fwd_eof;
                sat_q   <= rot_sat;
            end else if (i_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_ready      = ready;
    assign o_rand_en    = rand_en;
    assign o_rand_reset = rand_reset;
    assign o_valid      = valid_q;
    assign o_i          = i_out_q;
    assign o_q          = q_out_q;
    assign o_sof        = sof_q;
    assign o_eof        = eof_q;
    assign o_sat        = sat_q;
    assign o_sync_err   = sync_err_q;

endmodule

// File: tb/tb_symbol_scrambler.sv
// Directed bench for symbol_scrambler (W=8, FRAME_LEN=4) with a small
// randomizer model tied to o_rand_en/o_rand_reset.
module tb_symbol_scrambler;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid, sof, ready_in;
    logic [7:0] di, dq;
    logic [1:0] r_w;
    logic       o_ready, o_rand_en, o_rand_reset, o_valid;
    logic [7:0] o_i, o_q;
    logic       o_sof, o_eof, o_sat, o_sync_err;

    logic       force_en;
    logic [1:0] force_r;
    logic [7:0] rs;
    logic [1:0] seq [4];

    int checks = 0;
    int errors = 0;

    logic        mon_en = 1'b0;
    int          ren_cnt = 0;
    logic [18:0] got_q [$];
    logic [18:0] exp_q [$];
    logic [18:0] frm [2][4];

    logic [7:0] rot_ei [3] = '{8'd7, 8'hFB, 8'hF9};
    logic [7:0] rot_eq [3] = '{8'd5, 8'd7,  8'hFB};

    localparam logic [7:0] SEED = 8'hA4;

    always #5 clk = ~clk;

    symbol_scrambler #(.W(8), .FRAME_LEN(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(o_ready),
        .i_sof(sof), .i_i(di), .i_q(dq), .i_r(r_w),
        .o_rand_en(o_rand_en), .o_rand_reset(o_rand_reset),
        .o_valid(o_valid), .i_ready(ready_in), .o_i(o_i), .o_q(o_q),
        .o_sof(o_sof), .o_eof(o_eof), .o_sat(o_sat), .o_sync_err(o_sync_err)
    );

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    // Randomizer model: sync reset to seed, one step per enable.
    always @(posedge clk) begin
        if (o_rand_reset) rs <= SEED;
        else if (o_rand_en) rs <= lfsr_step(rs);
    end
    assign r_w = force_en ? force_r : rs[1:0];

    // Reference rotation in integer arithmetic with clamping.
    function automatic logic [16:0] ref_rot(input int i, input int q, input int r);
        int oi, oq;
        logic s;
        case (r)
            1: begin oi = -q; oq = i;  end
            2: begin oi = -i; oq = -q; end
            3: begin oi = q;  oq = -i; end
            default: begin oi = i; oq = q; end
        endcase
        s = 1'b0;
        if (oi > 127) begin oi = 127; s = 1'b1; end
        if (oq > 127) begin oq = 127; s = 1'b1; end
        return {s, 8'(oi), 8'(oq)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_rand_en) ren_cnt++;
            if (o_valid && ready_in) got_q.push_back({o_sof, o_eof, o_sat, o_i, o_q});
        end
    end

    initial begin
        logic [7:0] s;
        int acc;
        int tries;
        logic tmo;
        s = SEED;
        for (int k = 0; k < 4; k++) begin
            seq[k] = s[1:0];
            s = lfsr_step(s);
        end
        rst = 1'b1; valid = 1'b0; sof = 1'b0; di = '0; dq = '0;
        ready_in = 1'b1; force_en = 1'b0; force_r = '0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_valid", o_valid, 0);
        chk("rst_i", o_i, 0);
        chk("rst_q", o_q, 0);
        chk("rst_flags", {o_sof, o_eof, o_sat, o_sync_err}, 0);
        chk("rst_rand_reset", o_rand_reset, 1);
        chk("rst_rand_en", o_rand_en, 0);
        rst = 1'b0;
        nxt();

        // Seed check: frame start uses r=0
        valid = 1'b1; sof = 1'b1; di = 8'd10; dq = 8'hFD;
        #1;
        chk("seed_r", r_w, 0);
        chk("seed_ready", o_ready, 1);
        chk("seed_ctl", {o_rand_en, o_rand_reset}, 2'b10);
        nxt();
        chk("seed_out", {o_valid, o_sof, o_eof, o_sat, o_i, o_q}, {4'b1100, 8'd10, 8'hFD});

        // Rotation table on (5,-7), last one closes the frame
        force_en = 1'b1; sof = 1'b0; di = 8'd5; dq = 8'hF9;
        for (int r = 1; r <= 3; r++) begin
            force_r = 2'(r);
            #1;
            chk("rot_ctl", {o_rand_en, o_rand_reset}, (r == 3) ? 2'b01 : 2'b10);
            nxt();
            chk("rot_out", {o_valid, o_sof, o_eof, o_i, o_q}, {1'b1, 1'b0, (r == 3), rot_ei[r-1], rot_eq[r-1]});
        end

        // Saturation frame
        sof = 1'b1; di = 8'h80; dq = 8'h00; force_r = 2'd2;
        nxt();
        chk("sat_r2", {o_sof, o_sat, o_i, o_q}, {2'b11, 8'h7F, 8'h00});
        sof = 1'b0; di = 8'h00; dq = 8'h80; force_r = 2'd1;
        nxt();
        chk("sat_r1", {o_sof, o_sat, o_i, o_q}, {2'b01, 8'h7F, 8'h00});
        di = 8'd1; dq = 8'd2; force_r = 2'd0;
        nxt();
        chk("nosat", {o_sat, o_i, o_q}, {1'b0, 8'd1, 8'd2});
        di = 8'd3; dq = 8'd4;
        nxt();
        chk("sat_frame_eof", {o_eof, o_i, o_q}, {1'b1, 8'd3, 8'd4});

        // Non-sof symbol in IDLE is dropped
        di = 8'd1; dq = 8'd1;
        #1;
        chk("drop_ctl", {o_ready, o_rand_en, o_rand_reset}, 3'b101);
        nxt();
        chk("drop_err", {o_valid, o_sync_err}, 2'b01);
        valid = 1'b0;
        nxt();
        chk("drop_err_pulse", o_sync_err, 0);

        // Mid-frame sof after 2 symbols
        force_en = 1'b0;
        valid = 1'b1; sof = 1'b1; di = 8'd1; dq = 8'd1;
        nxt();
        sof = 1'b0; di = 8'd2; dq = 8'd2;
        nxt();
        chk("mid_sym1", {o_i, o_q}, 16'(ref_rot(2, 2, int'(seq[1]))));
        sof = 1'b1; di = 8'd9; dq = 8'd9;
        #1;
        chk("mid_ctl", {o_ready, o_rand_en, o_rand_reset}, 3'b001);
        nxt();
        chk("mid_err", {o_valid, o_sync_err}, 2'b01);
        #1;
        chk("mid_resend_ctl", {o_ready, o_rand_en, o_rand_reset}, 3'b110);
        nxt();
        chk("mid_resend_out", {o_valid, o_sof, o_sync_err, o_i, o_q}, {3'b110, 8'd9, 8'd9});
        valid = 1'b0; sof = 1'b0;

        // Async reset mid-frame clears output immediately
        rst = 1'b1;
        #1;
        chk("async_rst", {o_valid, o_rand_reset}, 2'b01);
        nxt();
        rst = 1'b0;
        nxt();

        // Back-to-back frames with equal input
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 4; k++) begin
                valid = 1'b1; sof = (k == 0);
                di = 8'(k * 3 + 1); dq = 8'(-(k * 5 + 2));
                #1;
                if (k == 3) chk("wrap_ctl", {o_rand_en, o_rand_reset}, 2'b01);
                nxt();
                frm[n][k] = {o_sof, o_eof, o_sat, o_i, o_q};
                chk("wrap_out", {o_valid, frm[n][k]},
                    {1'b1, (k == 0), (k == 3), ref_rot(k * 3 + 1, -(k * 5 + 2), int'(seq[k]))});
            end
        end
        for (int k = 0; k < 4; k++) chk("wrap_repeat", frm[1][k], frm[0][k]);
        valid = 1'b0;
        nxt();

        // Random backpressure over 1000 symbols
        mon_en = 1'b1;
        acc = 0;
        tmo = 1'b0;
        for (int n = 0; n < 1000 && !tmo; n++) begin
            int k;
            k = n % 4;
            while ($urandom_range(0, 3) == 0) begin
                valid = 1'b0; ready_in = 1'($urandom_range(0, 1));
                nxt();
            end
            valid = 1'b1; sof = (k == 0);
            di = 8'($urandom); dq = 8'($urandom);
            tries = 0;
            forever begin
                ready_in = 1'($urandom_range(0, 1));
                #1;
                if (o_ready) begin
                    exp_q.push_back({(k == 0), (k == 3),
                        ref_rot(int'($signed(di)), int'($signed(dq)), int'(seq[k]))});
                    acc++;
                    nxt();
                    break;
                end
                nxt();
                tries++;
                if (tries > 50) begin
                    chk("bp_timeout", 1, 0);
                    tmo = 1'b1;
                    break;
                end
            end
        end
        valid = 1'b0; sof = 1'b0; ready_in = 1'b1;
        repeat (3) nxt();
        mon_en = 1'b0;
        chk("bp_count", got_q.size(), exp_q.size());
        chk("bp_accepts", acc, 1000);
        // Every accept except a frame's last symbol advances the sequence.
        chk("bp_rand_en", ren_cnt, acc - acc / 4);
        for (int j = 0; j < got_q.size() && j < exp_q.size(); j++)
            chk("bp_data", got_q[j], exp_q[j]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
